// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: start-up freeze, load-use
// stalls, ID-stage redirects, memory-wait FSM with timeout and statistics counters.
module pipeline_stall_controller #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             load_use_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_hold_o,
    output logic             ifid_hold_o,
    output logic             ifid_flush_o,
    output logic             idex_hold_o,
    output logic             idex_bubble_o,
    output logic             exmem_hold_o,
    output logic             memwb_bubble_o,
    output logic             mem_error_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    localparam int                WAIT_W     = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    state_t            state_reg;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_next;

    logic freeze;
    logic pc_hold;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_hold;
    logic idex_bubble;
    logic exmem_hold;
    logic memwb_bubble;
    logic mem_error;
    logic mem_miss;

    // index 0: stall statistics, index 1: flush statistics
    logic [1:0]             cnt_inc;
    logic [CNT_W-1:0]       cnt_reg [2];

    assign mem_miss = dmem_req_i & ~dmem_ack_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        freeze        = 1'b0;
        pc_hold       = 1'b0;
        ifid_hold     = 1'b0;
        ifid_flush    = 1'b0;
        idex_hold     = 1'b0;
        idex_bubble   = 1'b0;
        exmem_hold    = 1'b0;
        memwb_bubble  = 1'b0;
        mem_error     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                freeze = 1'b1;
                if (start_i) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // A memory miss outranks every hazard; the hazards re-present after the wait.
                if (mem_miss) begin
                    freeze        = 1'b1;
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = WAIT_ONE;
                end else if (load_use_i) begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                end else if (branch_taken_i || jump_i) begin
                    ifid_flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ack_i) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == WAIT_LIMIT) begin
                    freeze     = 1'b1;
                    state_next = ST_ERROR;
                end else begin
                    freeze        = 1'b1;
                    wait_cnt_next = wait_cnt_reg + WAIT_ONE;
                end
            end
            ST_ERROR: begin
                freeze    = 1'b1;
                mem_error = 1'b1;
            end
        endcase

        if (freeze) begin
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_hold   = 1'b1;
            memwb_bubble = 1'b1;
        end
    end

    // IDLE and ERROR freezes are not stalls of running code, so they are not counted.
    assign cnt_inc[0] = pc_hold & ((state_reg == ST_RUN) | (state_reg == ST_MEM_WAIT));
    assign cnt_inc[1] = ifid_flush;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat_cnt
            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign pc_hold_o      = pc_hold;
    assign ifid_hold_o    = ifid_hold;
    assign ifid_flush_o   = ifid_flush;
    assign idex_hold_o    = idex_hold;
    assign idex_bubble_o  = idex_bubble;
    assign exmem_hold_o   = exmem_hold;
    assign memwb_bubble_o = memwb_bubble;
    assign mem_error_o    = mem_error;
    assign state_o        = state_reg;
    assign stall_cnt_o    = cnt_reg[0];
    assign flush_cnt_o    = cnt_reg[1];

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed vector table,
// hand-written saturation/reset sequences and randomized reference-model checks.
module tb_pipeline_stall_controller;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    // control vector order: pc_hold, ifid_hold, ifid_flush, idex_hold,
    // idex_bubble, exmem_hold, memwb_bubble, mem_error
    localparam logic [7:0] C_FRZ  = 8'b1101_0110;
    localparam logic [7:0] C_ERR  = 8'b1101_0111;
    localparam logic [7:0] C_LU   = 8'b1100_1000;
    localparam logic [7:0] C_FL   = 8'b0010_0000;
    localparam logic [7:0] C_NONE = 8'b0000_0000;

    // input vector order: rst, start, load_use, branch_taken, jump, dmem_req, dmem_ack
    localparam logic [6:0] I_IDLE  = 7'b1000000;
    localparam logic [6:0] I_START = 7'b1100000;
    localparam logic [6:0] I_LU    = 7'b1010000;
    localparam logic [6:0] I_LUBR  = 7'b1011000;
    localparam logic [6:0] I_BR    = 7'b1001000;
    localparam logic [6:0] I_JMP   = 7'b1000100;
    localparam logic [6:0] I_MISS  = 7'b1000010;
    localparam logic [6:0] I_ACKLU = 7'b1010011;
    localparam logic [6:0] I_RST   = 7'b0000000;
    localparam logic [6:0] I_RSTMS = 7'b0000010;

    logic             clk_i;
    logic             rst_i;
    logic             start_i;
    logic             load_use_i;
    logic             branch_taken_i;
    logic             jump_i;
    logic             dmem_req_i;
    logic             dmem_ack_i;
    logic             pc_hold_o;
    logic             ifid_hold_o;
    logic             ifid_flush_o;
    logic             idex_hold_o;
    logic             idex_bubble_o;
    logic             exmem_hold_o;
    logic             memwb_bubble_o;
    logic             mem_error_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic [7:0]       ctrl_w;

    pipeline_stall_controller #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .load_use_i    (load_use_i),
        .branch_taken_i(branch_taken_i),
        .jump_i        (jump_i),
        .dmem_req_i    (dmem_req_i),
        .dmem_ack_i    (dmem_ack_i),
        .pc_hold_o     (pc_hold_o),
        .ifid_hold_o   (ifid_hold_o),
        .ifid_flush_o  (ifid_flush_o),
        .idex_hold_o   (idex_hold_o),
        .idex_bubble_o (idex_bubble_o),
        .exmem_hold_o  (exmem_hold_o),
        .memwb_bubble_o(memwb_bubble_o),
        .mem_error_o   (mem_error_o),
        .state_o       (state_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    assign ctrl_w = {pc_hold_o, ifid_hold_o, ifid_flush_o, idex_hold_o,
                     idex_bubble_o, exmem_hold_o, memwb_bubble_o, mem_error_o};

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model: state as the numeric code, MEM_WAIT progress as cycles elapsed.
    int m_state = 0;
    int m_mw    = 0;
    int m_stall = 0;
    int m_flush = 0;

    typedef struct {
        logic [6:0] in;
        logic [7:0] ctrl;
        int         st;
        int         stall;
        int         flush;
    } vec_t;

    vec_t tbl[25];

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic apply(input logic [6:0] v);
        @(negedge clk_i);
        {rst_i, start_i, load_use_i, branch_taken_i, jump_i, dmem_req_i, dmem_ack_i} = v;
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] c, input int st,
                             input int stall, input int flush);
        $display("%s in=%b ctrl=%b state=%0d stall=%0d flush=%0d", tag,
                 {rst_i, start_i, load_use_i, branch_taken_i, jump_i, dmem_req_i, dmem_ack_i},
                 ctrl_w, state_o, stall_cnt_o, flush_cnt_o);
        check_val({tag, " ctrl"}, int'(ctrl_w), int'(c));
        check_val({tag, " state"}, int'(state_o), st);
        check_val({tag, " stall_cnt"}, int'(stall_cnt_o), stall);
        check_val({tag, " flush_cnt"}, int'(flush_cnt_o), flush);
    endtask

    function automatic logic [7:0] model_ctrl(input int st, input logic [6:0] v);
        logic miss;
        miss = v[1] && !v[0];
        case (st)
            0:       return C_FRZ;
            3:       return C_ERR;
            2:       return v[0] ? C_NONE : C_FRZ;
            default: begin
                if (miss)              return C_FRZ;
                else if (v[4])         return C_LU;
                else if (v[3] || v[2]) return C_FL;
                else                   return C_NONE;
            end
        endcase
    endfunction

    task automatic model_step(input logic [6:0] v);
        bit miss;
        bit stalled;
        bit flushed;
        miss    = v[1] && !v[0];
        stalled = 0;
        flushed = 0;
        if (!v[6]) begin
            m_state = 0;
            m_mw    = 0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            case (m_state)
                0: if (v[5]) m_state = 1;
                1: begin
                    stalled = miss || v[4];
                    flushed = !miss && !v[4] && (v[3] || v[2]);
                    if (miss) begin
                        m_state = 2;
                        m_mw    = 0;
                    end
                end
                2: begin
                    if (v[0]) m_state = 1;
                    else begin
                        stalled = 1;
                        m_mw++;
                        if (m_mw == TIMEOUT) m_state = 3;
                    end
                end
                default: ;
            endcase
            if (stalled && m_stall < CMAX) m_stall++;
            if (flushed && m_flush < CMAX) m_flush++;
        end
    endtask

    task automatic cycle_const(input string tag, input logic [6:0] v, input logic [7:0] c,
                               input int st, input int stall, input int flush);
        apply(v);
        check_all(tag, c, st, stall, flush);
        model_step(v);
    endtask

    initial begin
        logic [6:0] v;

        tbl[0]  = '{I_IDLE,  C_FRZ,  0, 0,  0};
        tbl[1]  = '{I_IDLE,  C_FRZ,  0, 0,  0};
        tbl[2]  = '{I_IDLE,  C_FRZ,  0, 0,  0};
        tbl[3]  = '{I_START, C_FRZ,  0, 0,  0};
        tbl[4]  = '{I_IDLE,  C_NONE, 1, 0,  0};
        tbl[5]  = '{I_LU,    C_LU,   1, 0,  0};
        tbl[6]  = '{I_IDLE,  C_NONE, 1, 1,  0};
        tbl[7]  = '{I_LUBR,  C_LU,   1, 1,  0};
        tbl[8]  = '{I_BR,    C_FL,   1, 2,  0};
        tbl[9]  = '{I_IDLE,  C_NONE, 1, 2,  1};
        tbl[10] = '{I_MISS,  C_FRZ,  1, 2,  1};
        tbl[11] = '{I_MISS,  C_FRZ,  2, 3,  1};
        tbl[12] = '{I_MISS,  C_FRZ,  2, 4,  1};
        tbl[13] = '{I_ACKLU, C_NONE, 2, 5,  1};
        tbl[14] = '{I_IDLE,  C_NONE, 1, 5,  1};
        tbl[15] = '{I_MISS,  C_FRZ,  1, 5,  1};
        tbl[16] = '{I_MISS,  C_FRZ,  2, 6,  1};
        tbl[17] = '{I_MISS,  C_FRZ,  2, 7,  1};
        tbl[18] = '{I_MISS,  C_FRZ,  2, 8,  1};
        tbl[19] = '{I_MISS,  C_FRZ,  2, 9,  1};
        tbl[20] = '{I_START, C_ERR,  3, 10, 1};
        tbl[21] = '{I_IDLE,  C_ERR,  3, 10, 1};
        tbl[22] = '{I_RST,   C_ERR,  3, 10, 1};
        tbl[23] = '{I_IDLE,  C_FRZ,  0, 0,  0};
        tbl[24] = '{I_START, C_FRZ,  0, 0,  0};

        {rst_i, start_i, load_use_i, branch_taken_i, jump_i, dmem_req_i, dmem_ack_i} = I_RST;
        for (int i = 0; i < 2; i++) begin
            apply(I_RST);
            model_step(I_RST);
        end

        for (int i = 0; i < 25; i++) begin
            cycle_const($sformatf("vec%0d", i), tbl[i].in, tbl[i].ctrl, tbl[i].st,
                        tbl[i].stall, tbl[i].flush);
        end

        // flush counter saturation under back-to-back jumps
        for (int i = 0; i < 20; i++) begin
            cycle_const($sformatf("jmp%0d", i), I_JMP, C_FL, 1, 0, (i < CMAX) ? i : CMAX);
        end
        cycle_const("jmp_end", I_IDLE, C_NONE, 1, 0, CMAX);

        // reset arriving mid MEM_WAIT
        cycle_const("rmw_miss", I_MISS, C_FRZ, 1, 0, CMAX);
        cycle_const("rmw_wait", I_MISS, C_FRZ, 2, 1, CMAX);
        cycle_const("rmw_rst", I_RSTMS, C_FRZ, 2, 2, CMAX);
        cycle_const("rmw_post", I_IDLE, C_FRZ, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            v[6] = ($urandom_range(0, 49) != 0);
            v[5] = ($urandom_range(0, 3) == 0);
            v[4] = ($urandom_range(0, 3) == 0);
            v[3] = ($urandom_range(0, 3) == 0);
            v[2] = ($urandom_range(0, 3) == 0);
            v[1] = ($urandom_range(0, 2) == 0);
            v[0] = ($urandom_range(0, 1) == 0);
            cycle_const($sformatf("rnd%0d", i), v, model_ctrl(m_state, v), m_state,
                        m_stall, m_flush);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Merges load-use hazard requests from the hazard detection unit, ID-stage branch/jump redirects and a data-memory ready handshake into per-stage hold/bubble/flush controls.
- Owns the start-up freeze, the memory-wait state machine with timeout, and stall/flush statistics counters.
- Sits beside the pipeline registers; its outputs drive the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers directly.

Parameters:
- TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before the error state; must be ≥1.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-low reset.
- start_i  in  1  leave IDLE and begin execution.
- load_use_i  in  1  load-use hazard from the hazard detection unit.
- branch_taken_i  in  1  branch resolved taken in ID.
- jump_i  in  1  jump decoded in ID.
- dmem_req_i  in  1  MEM-stage instruction accesses data memory.
- dmem_ack_i  in  1  data memory completes access this cycle.
- pc_hold_o  out  1  PC keeps its value.
- ifid_hold_o  out  1  IF/ID keeps its contents.
- ifid_flush_o  out  1  IF/ID loads NOP.
- idex_hold_o  out  1  ID/EX keeps its contents.
- idex_bubble_o  out  1  ID/EX control fields cleared.
- exmem_hold_o  out  1  EX/MEM keeps its contents.
- memwb_bubble_o  out  1  MEM/WB control fields cleared.
- mem_error_o  out  1  memory timeout; pipeline frozen.
- state_o  out  2  current FSM state.
- stall_cnt_o  out  CNT_W  saturating count of stall cycles.
- flush_cnt_o  out  CNT_W  saturating count of flushes.

Behaviour:
- State encoding: IDLE=0, RUN=1, MEM_WAIT=2, ERROR=3.
- Reset (rst_i=0 at a clock edge):
  - state goes to IDLE; wait counter and both statistics counters clear to 0.
  - Reset has priority over every input in every state, including mid-MEM_WAIT and ERROR.
- Outputs are combinational from the registered state plus the current inputs. The hold/bubble/flush outputs therefore take effect in the same cycle as their cause.
- "Freeze" means pc_hold_o, ifid_hold_o, idex_hold_o and exmem_hold_o are all 1, memwb_bubble_o=1, and all other controls are 0.
- IDLE:
  - Outputs: freeze.
  - Transition: start_i=1 → RUN at the next edge.
- RUN, first matching rule wins:
  1. dmem_req_i=1 and dmem_ack_i=0 (memory miss): freeze. Next state MEM_WAIT, wait counter loaded with 1. Any load-use, branch or jump request is suppressed and is re-evaluated after the wait.
  2. load_use_i=1: pc_hold_o, ifid_hold_o and idex_bubble_o all 1. Any branch_taken_i/jump_i is suppressed, because the branch operands are not yet valid.
  3. branch_taken_i=1 or jump_i=1: ifid_flush_o=1 and the PC updates normally.
  4. Otherwise all controls are 0.
- MEM_WAIT:
  - dmem_ack_i=1: all controls 0 and the pipeline advances this cycle. The hazard inputs are ignored in this cycle. Next state RUN.
  - dmem_ack_i=0 and wait counter = TIMEOUT: freeze; next state ERROR.
  - Otherwise: freeze; wait counter increments.
- ERROR:
  - Outputs: freeze, mem_error_o=1.
  - Exit: reset only; start_i is ignored.
- mem_error_o is 0 in every state except ERROR.
- stall_cnt_o:
  - Increments in any RUN or MEM_WAIT cycle where pc_hold_o=1.
  - Does not count in IDLE or ERROR.
  - Saturates at 2^CNT_W−1.
- flush_cnt_o:
  - Increments on each cycle where ifid_flush_o=1.
  - Saturates at 2^CNT_W−1.
- Hold and bubble/flush of the same register are never asserted together:
  - ifid_hold_o and ifid_flush_o are mutually exclusive.
  - idex_hold_o and idex_bubble_o are mutually exclusive.

Test Plan:
- Reset then idle: rst_i=0 for 2 cycles, then start_i=0 for 3 cycles → state_o=0, freeze outputs active, stall_cnt_o=0. Pulse start_i → state_o=1 next cycle, all controls 0.
- Load-use in RUN: load_use_i=1 for 1 cycle → pc_hold_o=ifid_hold_o=idex_bubble_o=1 in that cycle, stall_cnt_o goes from 0 to 1.
- Load-use with taken branch in the same cycle: load_use_i=branch_taken_i=1 → ifid_flush_o=0 and flush_cnt_o unchanged. Next cycle branch_taken_i=1 alone → ifid_flush_o=1, flush_cnt_o=1.
- Memory miss of 3 cycles:
  - RUN cycle with dmem_req_i=1, dmem_ack_i=0 → freeze, then state_o=2.
  - dmem_ack_i=0 for 2 more cycles, then dmem_ack_i=1 → controls 0 that cycle, then state_o=1.
  - stall_cnt_o=3.
- Timeout with TIMEOUT=4 and dmem_ack_i held 0:
  - state_o=2 with 4 freeze cycles, then state_o=3 and mem_error_o=1.
  - Asserting start_i has no effect.
  - rst_i=0 → state_o=0, mem_error_o=0.
- Counter saturation with CNT_W=4: 20 consecutive jump_i cycles → flush_cnt_o stops at 15. Reset during MEM_WAIT → state_o=0 and counters 0 at the next edge.
